// File: rtl/slap_hs_ram_arbiter.sv
// ---------------------------------------------------------------------------
// slap_hs_ram_arbiter
//
// Shares the single-port work RAM between the Z80 CPU bus and the hiscore
// engine. When hiscore signals intent, the CPU is paused and any CPU access
// already in flight completes. The RAM is then granted to hiscore. Once both
// intents drop, the RAM goes back to the CPU after a short hold-off window.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   defined   : a watchdog limits how long hiscore may own the RAM
//               (WDOG_CYC cycles without activity). On expiry it forces the
//               release path and pulses wdog_fire. Intents are then ignored
//               until both have dropped.
//   undefined : no watchdog. Ownership lasts while intent is held, and
//               wdog_fire is tied 0.
//
// Ports
//   clkm_48MHZ    in   system clock, rising edge
//   RESET_n       in   asynchronous active-low reset
//   cpu_req       in   CPU access request (level)
//   cpu_we        in   CPU write select
//   cpu_addr      in   CPU address [AW]
//   cpu_wdata     in   CPU write data [DW]
//   cpu_rdata     out  CPU read data, valid with cpu_ack [DW]
//   cpu_ack       out  one-cycle completion pulse
//   hs_intent_rd  in   hiscore requests read ownership
//   hs_intent_wr  in   hiscore requests write ownership
//   hs_addr       in   hiscore address [AW]
//   hs_wdata      in   hiscore write data [DW]
//   hs_we         in   hiscore write strobe (only while hs_grant=1)
//   hs_rdata      out  hiscore read data, 2 cycles after hs_addr [DW]
//   hs_grant      out  RAM is owned by hiscore
//   pause_cpu     out  stalls the CPU
//   ram_addr      out  registered RAM address [AW]
//   ram_we        out  registered RAM write enable
//   ram_wdata     out  registered RAM write data [DW]
//   ram_rdata     in   RAM read data, 1 cycle after ram_addr [DW]
//   wdog_fire     out  one-cycle watchdog pulse
//   dbg_state     out  FSM state: 0=CPU 1=DRAIN 2=HS 3=RELEASE
//
// Handshake: the CPU holds cpu_req high until it sees cpu_ack. It must drop
// cpu_req in the cycle after the ack, or a new access is started.
// ---------------------------------------------------------------------------
module slap_hs_ram_arbiter #(
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int RELEASE_CYC = 4,
   parameter int WDOG_CYC    = 1024
) (
   input  logic          clkm_48MHZ,
   input  logic          RESET_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          hs_intent_rd,
   input  logic          hs_intent_wr,
   input  logic [AW-1:0] hs_addr,
   input  logic [DW-1:0] hs_wdata,
   input  logic          hs_we,
   output logic [DW-1:0] hs_rdata,
   output logic          hs_grant,
   output logic          pause_cpu,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          wdog_fire,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_CPU     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_HS      = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam int RCW = (RELEASE_CYC < 2) ? 1 : $clog2(RELEASE_CYC + 1);

   state_t          r_state;
   logic [RCW-1:0]  r_rel_cnt;
   logic            r_acc1;      // CPU access: address issued to RAM
   logic            r_acc2;      // CPU access: RAM data arriving, ack next
   logic            r_wr1;
   logic            r_wr2;
   logic [DW-1:0]   r_cpu_rdata;
   logic            r_cpu_ack;
   logic [DW-1:0]   r_hs_rdata;
   logic            r_hs_grant;
   logic            r_pause;
   logic [AW-1:0]   r_ram_addr;
   logic            r_ram_we;
   logic [DW-1:0]   r_ram_wdata;

   logic            w_intent_raw;
   logic            w_intent;
   logic            w_wdog_hit;
   logic            w_inflight;
   logic            w_cpu_start;

   assign w_intent_raw = hs_intent_rd | hs_intent_wr;
   assign w_inflight   = r_acc1 | r_acc2;
   assign w_cpu_start  = (r_state == ST_CPU) && !w_inflight && cpu_req;

`ifdef ARB_WATCHDOG_EN
   localparam int WCW = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC);

   logic [WCW-1:0]  r_wdog_cnt;
   logic [1:0]      r_intent_q;
   logic            r_wdog_lock;  // set on expiry, cleared once both intents are low
   logic            r_wdog_fire;
   logic            w_wdog_clr;

   // Any change of either intent, or a hiscore write, counts as activity.
   assign w_wdog_clr = ({hs_intent_rd, hs_intent_wr} != r_intent_q) | hs_we;
   assign w_wdog_hit = (r_state == ST_HS) && !w_wdog_clr &&
                       (r_wdog_cnt == WCW'(WDOG_CYC - 1));
   assign w_intent   = w_intent_raw & ~r_wdog_lock;
   assign wdog_fire  = r_wdog_fire;

   always_ff @(posedge clkm_48MHZ or negedge RESET_n) begin
      if (!RESET_n) begin
         r_wdog_cnt  <= '0;
         r_intent_q  <= 2'b00;
         r_wdog_lock <= 1'b0;
         r_wdog_fire <= 1'b0;
      end else begin
         r_intent_q  <= {hs_intent_rd, hs_intent_wr};
         r_wdog_fire <= w_wdog_hit;
         if (r_state != ST_HS || w_wdog_clr || w_wdog_hit)
            r_wdog_cnt <= '0;
         else
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
         if (w_wdog_hit)
            r_wdog_lock <= 1'b1;
         else if (!w_intent_raw)
            r_wdog_lock <= 1'b0;
      end
   end
`else
   assign w_wdog_hit = 1'b0;
   assign w_intent   = w_intent_raw;
   assign wdog_fire  = 1'b0;
`endif

   always_ff @(posedge clkm_48MHZ or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state     <= ST_CPU;
         r_rel_cnt   <= '0;
         r_acc1      <= 1'b0;
         r_acc2      <= 1'b0;
         r_wr1       <= 1'b0;
         r_wr2       <= 1'b0;
         r_cpu_rdata <= '0;
         r_cpu_ack   <= 1'b0;
         r_hs_rdata  <= '0;
         r_hs_grant  <= 1'b0;
         r_pause     <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_wdata <= '0;
      end else begin
         // The CPU access pipeline advances in every state, so an access
         // accepted just before a hiscore request still completes during DRAIN.
         r_acc1    <= w_cpu_start;
         r_wr1     <= w_cpu_start & cpu_we;
         r_acc2    <= r_acc1;
         r_wr2     <= r_wr1;
         r_cpu_ack <= r_acc2;
         if (r_acc2 && !r_wr2)
            r_cpu_rdata <= ram_rdata;

         // Writes last a single cycle unless a state re-asserts them.
         r_ram_we <= 1'b0;

         case (r_state)
            ST_CPU: begin
               if (w_cpu_start) begin
                  r_ram_addr  <= cpu_addr;
                  r_ram_wdata <= cpu_wdata;
                  r_ram_we    <= cpu_we;
               end
               if (w_intent) begin
                  r_state <= ST_DRAIN;
                  r_pause <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!w_inflight) begin
                  r_state    <= ST_HS;
                  r_hs_grant <= 1'b1;
               end
            end
            ST_HS: begin
               r_ram_addr  <= hs_addr;
               r_ram_wdata <= hs_wdata;
               r_hs_rdata  <= ram_rdata;
               if (!w_intent || w_wdog_hit) begin
                  r_state    <= ST_RELEASE;
                  r_hs_grant <= 1'b0;
                  r_rel_cnt  <= RCW'(RELEASE_CYC);
               end else begin
                  r_ram_we <= hs_we & r_hs_grant;
               end
            end
            ST_RELEASE: begin
               // Leaving when the count is 1 makes the CPU state appear exactly
               // RELEASE_CYC edges after the drop; a count of 0 leaves next edge.
               if (w_intent) begin
                  r_state    <= ST_HS;
                  r_hs_grant <= 1'b1;
               end else if (r_rel_cnt <= RCW'(1)) begin
                  r_state <= ST_CPU;
                  r_pause <= 1'b0;
               end else begin
                  r_rel_cnt <= r_rel_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign cpu_ack   = r_cpu_ack;
   assign hs_rdata  = r_hs_rdata;
   assign hs_grant  = r_hs_grant;
   assign pause_cpu = r_pause;
   assign ram_addr  = r_ram_addr;
   assign ram_we    = r_ram_we;
   assign ram_wdata = r_ram_wdata;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_slap_hs_ram_arbiter.sv
// Bench for slap_hs_ram_arbiter: directed steps with a behavioural RAM,
// an expected-memory model and read-data queues for CPU and hiscore reads.
module tb_slap_hs_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam logic [1:0] S_CPU = 2'd0, S_DRAIN = 2'd1, S_HS = 2'd2, S_REL = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic RESET_n;

   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_ack;
   logic          hs_intent_rd, hs_intent_wr, hs_we;
   logic [AW-1:0] hs_addr;
   logic [DW-1:0] hs_wdata, hs_rdata;
   logic          hs_grant, pause_cpu;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          wdog_fire;
   logic [1:0]    dbg_state;

   slap_hs_ram_arbiter #(.AW(AW), .DW(DW), .RELEASE_CYC(4), .WDOG_CYC(16)) dut (
      .clkm_48MHZ(clk), .RESET_n(RESET_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .hs_intent_rd(hs_intent_rd), .hs_intent_wr(hs_intent_wr), .hs_addr(hs_addr),
      .hs_wdata(hs_wdata), .hs_we(hs_we), .hs_rdata(hs_rdata), .hs_grant(hs_grant),
      .pause_cpu(pause_cpu), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .wdog_fire(wdog_fire), .dbg_state(dbg_state)
   );

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // ---------------- behavioural RAM (1-cycle read latency) ----------------
   logic [7:0] mem [0:65535];
   logic       ram_init_done = 1'b0;
   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < 65536; i++) mem[i] <= init_val(i[15:0]);
         ram_init_done <= 1'b1;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_mem [logic [15:0]];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] hs_q[$];
   logic [DW-1:0] last_rd;
   int n_checks = 0;
   int n_err = 0;

   function automatic logic [7:0] exp_rd(input logic [15:0] a);
      if (exp_mem.exists(a)) return exp_mem[a];
      return init_val(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   function automatic logic [DW-1:0] pop_hs();
      if (hs_q.size() == 0) return 'x;
      return hs_q.pop_front();
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d);
      logic [7:0] e;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      if (!we) exp_q.push_back(exp_rd(a));
      else exp_mem[a] = d;
      tick();
      check("cpu_ram_addr", ram_addr, a);
      check("cpu_ram_we", ram_we, we);
      if (we) check("cpu_ram_wdata", ram_wdata, d);
      check("cpu_ack_n0", cpu_ack, 1'b0);
      tick();
      check("cpu_we_one_cycle", ram_we, 1'b0);
      check("cpu_ack_n1", cpu_ack, 1'b0);
      tick();
      check("cpu_ack_n2", cpu_ack, 1'b1);
      if (!we) begin
         e = pop_exp();
         check("cpu_rdata", cpu_rdata, e);
         last_rd = e;
      end else begin
         check("cpu_rdata_hold", cpu_rdata, last_rd);
      end
      cpu_req = 1'b0;
      tick();
      check("cpu_ack_pulse", cpu_ack, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int cyc;
      logic [15:0] ra;
      logic [7:0]  rd;
      RESET_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      hs_intent_rd = 1'b0; hs_intent_wr = 1'b0; hs_addr = '0; hs_wdata = '0; hs_we = 1'b0;
      last_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_hs_rdata", hs_rdata, 0);
      check("rst_hs_grant", hs_grant, 0);
      check("rst_pause", pause_cpu, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_wdog", wdog_fire, 0);
      check("rst_state", dbg_state, S_CPU);
      RESET_n = 1'b1;

      // first access right after reset, then write/read-back
      cpu_access(1'b0, 16'h0100, 8'h00);
      cpu_access(1'b1, 16'hC000, 8'h55);
      cpu_access(1'b0, 16'hC000, 8'h00);
      for (int k = 0; k < 4; k++) begin
         ra = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
         rd = 8'($urandom_range(0, 255));
         cpu_access(1'b1, ra, rd);
         cpu_access(1'b0, ra, 8'h00);
      end

      // cpu_req held past the ack starts a second access
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000;
      exp_q.push_back(exp_rd(16'hC000));
      tick(); tick(); tick();
      check("b2b_ack1", cpu_ack, 1);
      check("b2b_rdata1", cpu_rdata, pop_exp());
      cpu_addr = 16'h0100;
      exp_q.push_back(exp_rd(16'h0100));
      tick();
      check("b2b_restart_addr", ram_addr, 16'h0100);
      check("b2b_ack_low", cpu_ack, 0);
      tick(); tick();
      check("b2b_ack2", cpu_ack, 1);
      check("b2b_rdata2", cpu_rdata, pop_exp());
      cpu_req = 1'b0;
      tick();

      // idle CPU, hiscore takes ownership
      hs_intent_wr = 1'b1;
      tick();
      check("hs_pause_edge", pause_cpu, 1);
      check("hs_grant_not_yet", hs_grant, 0);
      check("hs_state_drain", dbg_state, S_DRAIN);
      tick();
      check("hs_grant", hs_grant, 1);
      check("hs_state_hs", dbg_state, S_HS);
      hs_addr = 16'hC010; hs_wdata = 8'hAA; hs_we = 1'b1;
      exp_mem[16'hC010] = 8'hAA;
      tick();
      check("hs_ram_we", ram_we, 1);
      check("hs_ram_addr", ram_addr, 16'hC010);
      check("hs_ram_wdata", ram_wdata, 8'hAA);
      hs_we = 1'b0; hs_addr = 16'hC000;
      hs_q.push_back(exp_rd(16'hC000));
      tick();
      check("hs_we_drop", ram_we, 0);
      hs_addr = 16'h0100;
      hs_q.push_back(exp_rd(16'h0100));
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC010;
      exp_q.push_back(exp_rd(16'hC010));
      tick();
      check("hs_cpu_blocked_addr", ram_addr, 16'h0100);
      check("hs_cpu_no_ack", cpu_ack, 0);
      tick();
      check("hs_rdata_lat2_a", hs_rdata, pop_hs());
      tick();
      check("hs_rdata_lat2_b", hs_rdata, pop_hs());

      // release with the CPU request pending
      hs_intent_wr = 1'b0;
      tick();
      check("rel_state", dbg_state, S_REL);
      check("rel_grant", hs_grant, 0);
      check("rel_ram_we", ram_we, 0);
      for (int k = 1; k < 4; k++) begin
         tick();
         check("rel_pause_held", pause_cpu, 1);
      end
      tick();
      check("rel_pause_fall", pause_cpu, 0);
      check("rel_state_cpu", dbg_state, S_CPU);
      cyc = 0;
      while (cyc < 20 && !cpu_ack) begin
         tick();
         cyc++;
      end
      check("pending_ack_latency", cyc, 3);
      check("pending_rdata", cpu_rdata, pop_exp());
      cpu_req = 1'b0;
      tick();

      // cpu_req and intent together: access completes before grant
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000;
      exp_q.push_back(exp_rd(16'hC000));
      hs_intent_rd = 1'b1;
      tick();
      check("sim_ram_addr", ram_addr, 16'hC000);
      check("sim_state", dbg_state, S_DRAIN);
      check("sim_pause", pause_cpu, 1);
      tick();
      check("sim_grant_n1", hs_grant, 0);
      tick();
      check("sim_ack", cpu_ack, 1);
      check("sim_rdata", cpu_rdata, pop_exp());
      check("sim_grant_n2", hs_grant, 0);
      cpu_req = 1'b0;
      tick();
      check("sim_grant_after_ack", hs_grant, 1);

      // drop then reassert two cycles later
      hs_intent_rd = 1'b0;
      tick();
      check("re_state_rel", dbg_state, S_REL);
      check("re_pause0", pause_cpu, 1);
      tick();
      check("re_pause1", pause_cpu, 1);
      hs_intent_rd = 1'b1;
      tick();
      check("re_grant", hs_grant, 1);
      check("re_pause2", pause_cpu, 1);
      check("re_state_hs", dbg_state, S_HS);
      hs_intent_rd = 1'b0;
      tick();
      check("drop_state_rel", dbg_state, S_REL);
      cyc = 0;
      while (cyc < 20 && pause_cpu) begin
         tick();
         cyc++;
      end
      check("drop_pause_cycles", cyc, 4);

      // reset in the middle of an access: no ack
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000;
      tick();
      check("rst_mid_addr", ram_addr, 16'hC000);
      RESET_n = 1'b0;
      #1;
      check("rst_mid_ram_addr", ram_addr, 0);
      check("rst_mid_state", dbg_state, S_CPU);
      cpu_req = 1'b0;
      tick(); tick();
      check("rst_mid_no_ack", cpu_ack, 0);
      RESET_n = 1'b1;
      tick(); tick(); tick();
      check("rst_mid_no_ack_after", cpu_ack, 0);

`ifdef ARB_WATCHDOG_EN
      hs_intent_rd = 1'b1;
      tick();
      tick();
      check("wd_grant", hs_grant, 1);
      for (int k = 1; k < 16; k++) begin
         tick();
         check("wd_quiet", wdog_fire, 0);
      end
      tick();
      check("wd_fire", wdog_fire, 1);
      check("wd_grant_drop", hs_grant, 0);
      tick();
      check("wd_fire_pulse", wdog_fire, 0);
      tick(); tick();
      check("wd_pause_held", pause_cpu, 1);
      tick();
      check("wd_pause_fall", pause_cpu, 0);
      check("wd_state_cpu", dbg_state, S_CPU);
      tick(); tick(); tick();
      check("wd_intent_ignored", pause_cpu, 0);
      hs_intent_rd = 1'b0;
      tick();
      hs_intent_rd = 1'b1;
      tick();
      check("wd_reaccept", dbg_state, S_DRAIN);
      hs_intent_rd = 1'b0;
      cyc = 0;
      while (cyc < 20 && dbg_state != S_CPU) begin
         tick();
         cyc++;
      end
      check("wd_back_to_cpu", dbg_state, S_CPU);
`endif

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
